// File: rtl/dht11_sensor_emu.sv
// DHT11 sensor-side emulator: answers a host start pulse with the
// response preamble and a 40-bit humidity/temperature frame.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   dht11_in   in   raw bus level (asynchronous, synchronised here)
//   dht11_oe   out  1 = pull bus low, 0 = release (open-drain)
//   hum_int    in   humidity integer byte
//   hum_dec    in   humidity decimal byte
//   temp_int   in   temperature integer byte
//   temp_dec   in   temperature decimal byte
//   busy       out  high from accepted start until end-of-frame release
//   frame_done out  one-cycle pulse when the final low is released
//   bad_start  out  one-cycle pulse when a too-short host low ends
module dht11_sensor_emu #(
    parameter int CLK_DIV      = 50,
    parameter int START_MIN_US = 18000,
    parameter int WAIT_US      = 30,
    parameter int RESP_LOW_US  = 80,
    parameter int RESP_HIGH_US = 80,
    parameter int BIT_LOW_US   = 50,
    parameter int BIT0_HIGH_US = 26,
    parameter int BIT1_HIGH_US = 70
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dht11_in,
    output logic       dht11_oe,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    output logic       busy,
    output logic       frame_done,
    output logic       bad_start
);

    localparam int START_CYC = START_MIN_US * CLK_DIV;
    localparam int SPAN_CYC  = START_CYC
        + (WAIT_US + RESP_LOW_US + RESP_HIGH_US
           + BIT_LOW_US + BIT1_HIGH_US) * CLK_DIV;
    localparam int CW = $clog2(SPAN_CYC + 1) + 1;

    localparam logic [CW-1:0] START_MIN = CW'(START_CYC);
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_US * CLK_DIV - 1);
    localparam logic [CW-1:0] RLO_LAST  = CW'(RESP_LOW_US * CLK_DIV - 1);
    localparam logic [CW-1:0] RHI_LAST  = CW'(RESP_HIGH_US * CLK_DIV - 1);
    localparam logic [CW-1:0] BLO_LAST  = CW'(BIT_LOW_US * CLK_DIV - 1);
    localparam logic [CW-1:0] B0_LAST   = CW'(BIT0_HIGH_US * CLK_DIV - 1);
    localparam logic [CW-1:0] B1_LAST   = CW'(BIT1_HIGH_US * CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_LOW,
        S_WAIT_REL,
        S_RESP_LOW,
        S_RESP_HIGH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_END_LOW
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    bit_q, bit_d;
    logic [39:0]   frame_q, frame_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          frame_done_q, frame_done_d;
    logic          bad_start_q, bad_start_d;

    logic [CW-1:0] dur_last;
    logic          at_last;
    logic [7:0]    chk_sum;

    // Two-flop synchroniser; idles high like a pulled-up bus.
    always_comb begin
        sync1_d = dht11_in;
        sync2_d = sync1_q;
    end

    assign chk_sum = hum_int + hum_dec + temp_int + temp_dec;

    // Last cycle index of each timed state; frame_q[39] is the
    // bit currently on the wire.
    always_comb begin
        dur_last = '0;
        unique case (state_q)
            S_WAIT_REL:  dur_last = WAIT_LAST;
            S_RESP_LOW:  dur_last = RLO_LAST;
            S_RESP_HIGH: dur_last = RHI_LAST;
            S_BIT_LOW:   dur_last = BLO_LAST;
            S_BIT_HIGH:  dur_last = frame_q[39] ? B1_LAST : B0_LAST;
            S_END_LOW:   dur_last = BLO_LAST;
            default:     dur_last = '0;
        endcase
    end

    assign at_last = (cnt_q == dur_last);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        bit_d        = bit_q;
        frame_d      = frame_q;
        frame_done_d = 1'b0;
        bad_start_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // The first low cycle seen here already counts.
                if (!sync2_q) begin
                    state_d = S_START_LOW;
                    cnt_d   = CW'(1);
                end
            end

            S_START_LOW: begin
                if (!sync2_q) begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                end else if (cnt_q >= START_MIN) begin
                    state_d = S_WAIT_REL;
                    cnt_d   = '0;
                    bit_d   = '0;
                    frame_d = {hum_int, hum_dec,
                               temp_int, temp_dec, chk_sum};
                end else begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    bad_start_d = 1'b1;
                end
            end

            S_WAIT_REL: begin
                if (at_last) begin
                    state_d = S_RESP_LOW;
                    cnt_d   = '0;
                end
            end

            S_RESP_LOW: begin
                if (at_last) begin
                    state_d = S_RESP_HIGH;
                    cnt_d   = '0;
                end
            end

            S_RESP_HIGH: begin
                if (at_last) begin
                    state_d = S_BIT_LOW;
                    cnt_d   = '0;
                end
            end

            S_BIT_LOW: begin
                if (at_last) begin
                    state_d = S_BIT_HIGH;
                    cnt_d   = '0;
                end
            end

            S_BIT_HIGH: begin
                if (at_last) begin
                    cnt_d   = '0;
                    frame_d = {frame_q[38:0], 1'b0};
                    bit_d   = bit_q + 6'd1;
                    if (bit_q == 6'd39) begin
                        state_d = S_END_LOW;
                    end else begin
                        state_d = S_BIT_LOW;
                    end
                end
            end

            S_END_LOW: begin
                if (at_last) begin
                    state_d      = S_IDLE;
                    cnt_d        = '0;
                    frame_done_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            frame_q      <= '0;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            frame_done_q <= 1'b0;
            bad_start_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            frame_q      <= frame_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            frame_done_q <= frame_done_d;
            bad_start_q  <= bad_start_d;
        end
    end

    // Drive is decoded from the state register only, so the bus
    // is released on the same edge that enters IDLE.
    assign dht11_oe = (state_q == S_RESP_LOW) ||
                      (state_q == S_BIT_LOW)  ||
                      (state_q == S_END_LOW);

    assign busy = (state_q == S_WAIT_REL)  ||
                  (state_q == S_RESP_LOW)  ||
                  (state_q == S_RESP_HIGH) ||
                  (state_q == S_BIT_LOW)   ||
                  (state_q == S_BIT_HIGH)  ||
                  (state_q == S_END_LOW);

    assign frame_done = frame_done_q;
    assign bad_start  = bad_start_q;

endmodule

// File: tb/tb_dht11_sensor_emu.sv
// Bench for dht11_sensor_emu: host start pulses, frame decode
// from dht11_oe pulse widths, scoreboard of expected frames.
module tb_dht11_sensor_emu;

    localparam int DIV    = 2;
    localparam int SMIN   = 100;
    localparam int S_CYC  = SMIN * DIV;
    localparam int W_CYC  = 30 * DIV;
    localparam int RL_CYC = 80 * DIV;
    localparam int RH_CYC = 80 * DIV;
    localparam int BL_CYC = 50 * DIV;
    localparam int B0_CYC = 26 * DIV;
    localparam int B1_CYC = 70 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       host_low = 1'b0;
    logic       dht11_in;
    logic       dht11_oe;
    logic [7:0] hum_int  = 8'h00;
    logic [7:0] hum_dec  = 8'h00;
    logic [7:0] temp_int = 8'h00;
    logic [7:0] temp_dec = 8'h00;
    logic       busy;
    logic       frame_done;
    logic       bad_start;

    int total = 0;
    int bad   = 0;

    logic [39:0] exp_q[$];
    int          runs_len[$];
    int          runs_lvl[$];
    int          run_len  = 0;
    logic        prev_oe  = 1'b0;
    int          done_cnt = 0;
    int          bs_cnt   = 0;
    logic        oe_any   = 1'b0;
    logic        busy_any = 1'b0;

    assign dht11_in = ~(host_low | dht11_oe);

    always #5 clk = ~clk;

    dht11_sensor_emu #(
        .CLK_DIV     (DIV),
        .START_MIN_US(SMIN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dht11_in  (dht11_in),
        .dht11_oe  (dht11_oe),
        .hum_int   (hum_int),
        .hum_dec   (hum_dec),
        .temp_int  (temp_int),
        .temp_dec  (temp_dec),
        .busy      (busy),
        .frame_done(frame_done),
        .bad_start (bad_start)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] mk(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic [7:0] c,
                                       input logic [7:0] d);
        logic [7:0] s;
        s = a + b + c + d;
        return {a, b, c, d, s};
    endfunction

    task automatic check_frame();
        logic [39:0] got;
        logic [39:0] exp;
        int          hi;
        got = '0;
        chk("end_lvl", prev_oe, 1);
        chk("end_low", run_len, BL_CYC);
        chk("nruns", runs_len.size(), 83);
        if (runs_len.size() == 83) begin
            chk("wait_lvl", runs_lvl[0], 0);
            chk("wait_len", runs_len[0], W_CYC);
            chk("rlo_len", runs_len[1], RL_CYC);
            chk("rhi_len", runs_len[2], RH_CYC);
            for (int i = 0; i < 40; i++) begin
                hi = runs_len[4 + 2 * i];
                got = {got[38:0], (hi > (B0_CYC + B1_CYC) / 2)};
                chk("bit_low", runs_len[3 + 2 * i], BL_CYC);
                chk("bit_high", hi, got[0] ? B1_CYC : B0_CYC);
            end
        end
        if (exp_q.size() == 0) begin
            chk("unexpected_frame", 1, 0);
        end else begin
            exp = exp_q.pop_front();
            chk("frame", got, exp);
        end
    endtask

    // Monitor: run lengths of dht11_oe while busy, decoded at frame_done.
    always @(negedge clk) begin
        if (dht11_oe) oe_any = 1'b1;
        if (busy) busy_any = 1'b1;
        if (bad_start) bs_cnt++;
        if (rst) begin
            runs_len.delete();
            runs_lvl.delete();
            run_len = 0;
        end else if (busy) begin
            if (run_len == 0) begin
                prev_oe = dht11_oe;
                run_len = 1;
            end else if (dht11_oe == prev_oe) begin
                run_len++;
            end else begin
                runs_len.push_back(run_len);
                runs_lvl.push_back(int'(prev_oe));
                prev_oe = dht11_oe;
                run_len = 1;
            end
        end else begin
            if (frame_done) begin
                done_cnt++;
                check_frame();
            end
            runs_len.delete();
            runs_lvl.delete();
            run_len = 0;
        end
    end

    task automatic host_start(input int len);
        host_low = 1'b1;
        repeat (len) @(negedge clk);
        host_low = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != prev) break;
        end
        chk("done_cnt", done_cnt, prev + 1);
        repeat (30) @(negedge clk);
        #1;
        chk("done_once", done_cnt, prev + 1);
    endtask

    task automatic wait_busy();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (busy) break;
        end
        chk("busy_rise", busy, 1);
    endtask

    task automatic set_bytes(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
        hum_int  = a;
        hum_dec  = b;
        temp_int = c;
        temp_dec = d;
    endtask

    task automatic short_start(input int len);
        int b0;
        b0       = bs_cnt;
        oe_any   = 1'b0;
        busy_any = 1'b0;
        host_start(len);
        repeat (20) @(negedge clk);
        #1;
        chk("bad_start_cnt", bs_cnt, b0 + 1);
        chk("short_oe", oe_any, 0);
        chk("short_busy", busy_any, 0);
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_oe", dht11_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_bad", bad_start, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Nominal frame, checksum 0x50.
        set_bytes(8'h37, 8'h00, 8'h19, 8'h00);
        chk("model_chk", mk(8'h37, 8'h00, 8'h19, 8'h00), 40'h3700190050);
        exp_q.push_back(mk(hum_int, hum_dec, temp_int, temp_dec));
        host_start(S_CYC + 10);
        wait_done(done_cnt);

        // Too-short starts, including one cycle under the threshold.
        short_start(S_CYC / 2);
        short_start(S_CYC - 1);

        // Exactly at the threshold; checksum wraps to 0x00.
        set_bytes(8'hFF, 8'hFF, 8'h01, 8'h01);
        exp_q.push_back(mk(hum_int, hum_dec, temp_int, temp_dec));
        host_start(S_CYC);
        wait_done(done_cnt);

        // Input change mid-frame plus a host glitch: frame unaffected.
        set_bytes(8'h37, 8'h00, 8'h19, 8'h00);
        exp_q.push_back(mk(hum_int, hum_dec, temp_int, temp_dec));
        d0 = done_cnt;
        host_start(S_CYC + 3);
        wait_busy();
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (runs_len.size() >= 9) break;
        end
        hum_int = 8'h55;
        host_low = 1'b1;
        repeat (5) @(negedge clk);
        host_low = 1'b0;
        wait_done(d0);

        exp_q.push_back(mk(hum_int, hum_dec, temp_int, temp_dec));
        host_start(S_CYC + 1);
        wait_done(done_cnt);

        // Reset in the middle of the response low.
        d0 = done_cnt;
        host_start(S_CYC + 20);
        wait_busy();
        repeat (100) @(negedge clk);
        chk("mid_resp_oe", dht11_oe, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_oe", dht11_oe, 0);
        chk("abort_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        #1;
        chk("abort_no_done", done_cnt, d0);
        chk("abort_idle_oe", dht11_oe, 0);

        set_bytes(8'h2D, 8'h00, 8'h17, 8'h00);
        exp_q.push_back(mk(hum_int, hum_dec, temp_int, temp_dec));
        host_start(S_CYC + 50);
        wait_done(done_cnt);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
